// File: rtl/sha256_msg_sequencer.sv
// ============================================================================
// Module      : sha256_msg_sequencer
// Description : Front end for a SHA-256 compression core.
//               - Accepts a big-endian 32-bit word stream (valid/ready).
//               - Counts the message bit length.
//               - Adds the 0x80 byte, the zero fill and the 64-bit length.
//               - Issues each 512-bit block to the core.
//               - Chains each core digest into the next block.
//               - Registers the final digest.
// Ports       : clk, reset_n (async, active-low)
//               in_valid/in_ready/in_data/in_last/in_bytes - message stream
//               core_start/core_message/core_in            - block to core
//               core_done/core_sha256                      - core result
//               digest/digest_valid                        - final digest
//               busy                                       - not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sequencer #(
    parameter int NUM_WORDS = 16,
    parameter int LEN_W     = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       in_last,
    input  logic [1:0]                 in_bytes,
    output logic                       core_start,
    output logic [NUM_WORDS-1:0][31:0] core_message,
    output logic [7:0][31:0]           core_in,
    input  logic                       core_done,
    input  logic [7:0][31:0]           core_sha256,
    output logic [7:0][31:0]           digest,
    output logic                       digest_valid,
    output logic                       busy
);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_PAD   = 3'd2;
    localparam logic [2:0] C_START = 3'd3;
    localparam logic [2:0] C_WAIT  = 3'd4;
    localparam logic [2:0] C_EXTRA = 3'd5;
    localparam logic [2:0] C_OUT   = 3'd6;

    // Packed so that element 0 is H0.
    localparam logic [7:0][31:0] C_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    logic [2:0]                 state_q, state_d;
    logic [NUM_WORDS-1:0][31:0] block_q, block_d;
    logic [7:0][31:0]           chain_q, chain_d;
    logic [7:0][31:0]           digest_q, digest_d;
    logic                       dvalid_q, dvalid_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [3:0]                 idx_q, idx_d;
    logic [1:0]                 nb_q, nb_d;       // byte count of the last word
    logic                       final_q, final_d; // current block carries length
    logic                       extra_q, extra_d; // a length-only block follows
    logic                       carry_q, carry_d; // 0x80 spilled into the extra block

    logic        w_accept;
    logic [31:0] w_keep;
    logic [5:0]  w_add;
    logic [4:0]  w_pos;
    logic [63:0] w_len64;

    assign w_accept = in_valid && (state_q == C_LOAD);
    // A partial last word keeps only its high-order bytes.
    assign w_keep   = (in_last && in_bytes != 2'd0) ? ~(32'hffff_ffff >> {in_bytes, 3'b000}) : 32'hffff_ffff;
    assign w_add    = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes, 3'b000} : 6'd32;
    // Word that receives the 0x80 byte; 16 means it spills into an extra block.
    assign w_pos    = (nb_q != 2'd0) ? {1'b0, idx_q} : ({1'b0, idx_q} + 5'd1);
    assign w_len64  = 64'(len_q);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= C_IDLE;
        else          state_q <= state_d;
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  state_d = C_LOAD;
            C_LOAD: begin
                if (w_accept) begin
                    if (in_last)              state_d = C_PAD;
                    else if (idx_q == 4'd15)  state_d = C_START;
                end
            end
            C_PAD:   state_d = C_START;
            C_START: state_d = C_WAIT;
            C_WAIT: begin
                if (core_done) begin
                    if (final_q)      state_d = C_OUT;
                    else if (extra_q) state_d = C_EXTRA;
                    else              state_d = C_LOAD;
                end
            end
            C_EXTRA: state_d = C_START;
            C_OUT:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        in_ready   = (state_q == C_LOAD);
        core_start = (state_q == C_START);
        busy       = (state_q != C_IDLE);
    end

    assign core_message = block_q;
    assign core_in      = chain_q;
    assign digest       = digest_q;
    assign digest_valid = dvalid_q;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        block_d  = block_q;
        chain_d  = chain_q;
        digest_d = digest_q;
        dvalid_d = 1'b0;
        len_d    = len_q;
        idx_d    = idx_q;
        nb_d     = nb_q;
        final_d  = final_q;
        extra_d  = extra_q;
        carry_d  = carry_q;
        case (state_q)
            C_IDLE: begin
                chain_d = C_IV;
                len_d   = '0;
                idx_d   = '0;
                final_d = 1'b0;
                extra_d = 1'b0;
                carry_d = 1'b0;
            end
            C_LOAD: begin
                if (w_accept) begin
                    block_d[idx_q] = in_data & w_keep;
                    len_d          = len_q + LEN_W'(w_add);
                    nb_d           = in_last ? in_bytes : 2'd0;
                    if (!in_last && idx_q != 4'd15) idx_d = idx_q + 4'd1;
                end
            end
            C_PAD: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (i > int'(w_pos)) block_d[i] = '0;
                end
                if (nb_q != 2'd0)
                    block_d[idx_q] = block_q[idx_q] | (32'h8000_0000 >> {nb_q, 3'b000});
                else if (w_pos <= 5'd15)
                    block_d[w_pos[3:0]] = 32'h8000_0000;
                if (w_pos <= 5'd13) begin
                    block_d[14] = w_len64[63:32];
                    block_d[15] = w_len64[31:0];
                    final_d     = 1'b1;
                    extra_d     = 1'b0;
                    carry_d     = 1'b0;
                end else begin
                    final_d     = 1'b0;
                    extra_d     = 1'b1;
                    carry_d     = (w_pos == 5'd16);
                end
            end
            C_WAIT: begin
                if (core_done) begin
                    chain_d = core_sha256;
                    if (!final_q && !extra_q) idx_d = '0;
                end
            end
            C_EXTRA: begin
                block_d     = '0;
                block_d[0]  = carry_q ? 32'h8000_0000 : 32'h0;
                block_d[14] = w_len64[63:32];
                block_d[15] = w_len64[31:0];
                final_d     = 1'b1;
                extra_d     = 1'b0;
                carry_d     = 1'b0;
            end
            C_OUT: begin
                digest_d = chain_q;
                dvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_q  <= '0;
            chain_q  <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            nb_q     <= '0;
            final_q  <= 1'b0;
            extra_q  <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            block_q  <= block_d;
            chain_q  <= chain_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            nb_q     <= nb_d;
            final_q  <= final_d;
            extra_q  <= extra_d;
            carry_q  <= carry_d;
        end
    end

endmodule

`default_nettype wire
